// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - shared types and constants for the MIPS pipeline hazard controller
package mips_ctrl_pkg;

   // Sequencing states of the hazard controller
   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_MEM_WAIT = 2'd1,
      ST_DRAIN    = 2'd2,
      ST_HALTED   = 2'd3
   } ctrl_state_t;

   // $zero never carries a real dependency
   localparam logic [4:0] REG_ZERO = 5'd0;

   localparam int DEF_MEM_TIMEOUT  = 15;
   localparam int DEF_DRAIN_CYCLES = 4;

endpackage

// File: rtl/load_use_detect.sv
// rtl/load_use_detect.sv - combinational load-use hazard comparator
module load_use_detect
   import mips_ctrl_pkg::*;
(
   input  logic [4:0] id_rs,
   input  logic [4:0] id_rt,
   input  logic       id_uses_rt,
   input  logic       ex_mem_read,
   input  logic [4:0] ex_rt,
   output logic       hazard
);

   logic rs_match;
   logic rt_match;

   // A load into a register the ID instruction reads cannot be forwarded in time
   always_comb begin
      rs_match = (ex_rt == id_rs);
      rt_match = id_uses_rt && (ex_rt == id_rt);
      hazard   = ex_mem_read && (ex_rt != REG_ZERO) && (rs_match || rt_match);
   end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// rtl/pipeline_hazard_controller.sv - PC/pipeline-register sequencing and hazard resolution
module pipeline_hazard_controller
   import mips_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT  = DEF_MEM_TIMEOUT,
   parameter int DRAIN_CYCLES = DEF_DRAIN_CYCLES,
   parameter int CNT_W        = 16
)(
   input  logic             clk,
   input  logic             reset,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic             id_uses_rt,
   input  logic             ex_mem_read,
   input  logic [4:0]       ex_rt,
   input  logic             mem_branch_taken,
   input  logic             id_jump,
   input  logic             id_halt,
   input  logic             mem_access,
   input  logic             dmem_ready,
   output logic             pc_write,
   output logic             if_id_write,
   output logic             if_id_flush,
   output logic             id_ex_flush,
   output logic             ex_mem_flush,
   output logic             pipe_hold,
   output logic             halted,
   output logic             mem_timeout,
   output logic [CNT_W-1:0] stall_count,
   output logic [CNT_W-1:0] flush_count
);

   localparam int WAIT_W  = $clog2(MEM_TIMEOUT + 1);
   localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   ctrl_state_t        state;
   ctrl_state_t        nxt_state;
   logic [WAIT_W-1:0]  wait_cnt;
   logic [WAIT_W-1:0]  wait_inc;
   logic [WAIT_W-1:0]  wait_d;
   logic [DRAIN_W-1:0] drain_cnt;
   logic [DRAIN_W-1:0] drain_d;
   logic               load_use;
   logic               mem_stall;
   logic               freeze;
   logic               stall_inc;
   logic               flush_inc;
   logic               set_timeout;

   load_use_detect u_load_use (
      .id_rs       (id_rs),
      .id_rt       (id_rt),
      .id_uses_rt  (id_uses_rt),
      .ex_mem_read (ex_mem_read),
      .ex_rt       (ex_rt),
      .hazard      (load_use)
   );

   // Control outputs and next-state decision from current state and inputs
   always_comb begin
      nxt_state    = state;
      pc_write     = 1'b1;
      if_id_write  = 1'b1;
      if_id_flush  = 1'b0;
      id_ex_flush  = 1'b0;
      ex_mem_flush = 1'b0;
      pipe_hold    = 1'b0;
      halted       = 1'b0;
      freeze       = 1'b0;
      stall_inc    = 1'b0;
      flush_inc    = 1'b0;
      set_timeout  = 1'b0;
      drain_d      = drain_cnt;
      wait_inc     = wait_cnt + WAIT_W'(1);
      // once a wait is in progress, only dmem_ready can end it
      mem_stall    = !dmem_ready && (mem_access || (wait_cnt != '0));

      case (state)
         ST_RUN, ST_MEM_WAIT: begin
            nxt_state = ST_RUN;
            if (mem_stall) begin
               freeze    = 1'b1;
               nxt_state = ST_MEM_WAIT;
            end else if (mem_branch_taken) begin
               if_id_flush  = 1'b1;
               id_ex_flush  = 1'b1;
               ex_mem_flush = 1'b1;
               flush_inc    = 1'b1;
            end else if (id_halt) begin
               pc_write    = 1'b0;
               if_id_flush = 1'b1;
               id_ex_flush = 1'b1;
               nxt_state   = ST_DRAIN;
               drain_d     = '0;
            end else if (load_use) begin
               pc_write    = 1'b0;
               if_id_write = 1'b0;
               id_ex_flush = 1'b1;
               stall_inc   = 1'b1;
            end else if (id_jump) begin
               if_id_flush = 1'b1;
            end
         end
         ST_DRAIN: begin
            pc_write    = 1'b0;
            if_id_flush = 1'b1;
            if (mem_stall) begin
               freeze = 1'b1;
            end else if (mem_branch_taken) begin
               // halt was fetched down the wrong path
               pc_write     = 1'b1;
               id_ex_flush  = 1'b1;
               ex_mem_flush = 1'b1;
               flush_inc    = 1'b1;
               nxt_state    = ST_RUN;
            end else if (drain_cnt == DRAIN_W'(DRAIN_CYCLES - 1)) begin
               nxt_state = ST_HALTED;
            end else begin
               drain_d = drain_cnt + DRAIN_W'(1);
            end
         end
         ST_HALTED: begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            pipe_hold   = 1'b1;
            halted      = 1'b1;
         end
         default: nxt_state = ST_RUN;
      endcase

      if (freeze) begin
         pc_write     = 1'b0;
         if_id_write  = 1'b0;
         if_id_flush  = 1'b0;
         id_ex_flush  = 1'b0;
         ex_mem_flush = 1'b0;
         pipe_hold    = 1'b1;
         stall_inc    = 1'b1;
         if (wait_inc == WAIT_W'(MEM_TIMEOUT)) begin
            set_timeout = 1'b1;
            nxt_state   = ST_HALTED;
         end
      end
      wait_d = freeze ? wait_inc : '0;

      // reset forces bubbles everywhere without waiting for a clock edge
      if (reset) begin
         pc_write     = 1'b0;
         if_id_write  = 1'b0;
         if_id_flush  = 1'b1;
         id_ex_flush  = 1'b1;
         ex_mem_flush = 1'b1;
         pipe_hold    = 1'b0;
         halted       = 1'b0;
      end
   end

   // State, wait/drain counters, saturating perf counters and sticky timeout
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= ST_RUN;
         wait_cnt    <= '0;
         drain_cnt   <= '0;
         stall_count <= '0;
         flush_count <= '0;
         mem_timeout <= 1'b0;
      end else begin
         state     <= nxt_state;
         wait_cnt  <= wait_d;
         drain_cnt <= drain_d;
         if (stall_inc && (stall_count != CNT_MAX)) begin
            stall_count <= stall_count + CNT_W'(1);
         end
         if (flush_inc && (flush_count != CNT_MAX)) begin
            flush_count <= flush_count + CNT_W'(1);
         end
         if (set_timeout) begin
            mem_timeout <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// tb/tb_pipeline_hazard_controller.sv - directed self-checking bench for pipeline_hazard_controller
module tb_pipeline_hazard_controller;

   logic        clk;
   logic        reset;
   logic [4:0]  id_rs;
   logic [4:0]  id_rt;
   logic        id_uses_rt;
   logic        ex_mem_read;
   logic [4:0]  ex_rt;
   logic        mem_branch_taken;
   logic        id_jump;
   logic        id_halt;
   logic        mem_access;
   logic        dmem_ready;
   logic        pc_write;
   logic        if_id_write;
   logic        if_id_flush;
   logic        id_ex_flush;
   logic        ex_mem_flush;
   logic        pipe_hold;
   logic        halted;
   logic        mem_timeout;
   logic [15:0] stall_count;
   logic [15:0] flush_count;

   // {pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_flush, pipe_hold, halted}
   logic [6:0]  ctl;
   assign ctl = {pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_flush, pipe_hold, halted};

   localparam logic [6:0] C_RUN    = 7'b1100000;
   localparam logic [6:0] C_RESET  = 7'b0011100;
   localparam logic [6:0] C_LOAD   = 7'b0001000;
   localparam logic [6:0] C_BRANCH = 7'b1111100;
   localparam logic [6:0] C_JUMP   = 7'b1110000;
   localparam logic [6:0] C_FREEZE = 7'b0000010;
   localparam logic [6:0] C_HALT   = 7'b0111000;
   localparam logic [6:0] C_DRAIN  = 7'b0110000;
   localparam logic [6:0] C_HALTED = 7'b0000011;

   int n_checks = 0;
   int n_fail   = 0;

   pipeline_hazard_controller #(
      .MEM_TIMEOUT  (15),
      .DRAIN_CYCLES (4),
      .CNT_W        (16)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .id_rs            (id_rs),
      .id_rt            (id_rt),
      .id_uses_rt       (id_uses_rt),
      .ex_mem_read      (ex_mem_read),
      .ex_rt            (ex_rt),
      .mem_branch_taken (mem_branch_taken),
      .id_jump          (id_jump),
      .id_halt          (id_halt),
      .mem_access       (mem_access),
      .dmem_ready       (dmem_ready),
      .pc_write         (pc_write),
      .if_id_write      (if_id_write),
      .if_id_flush      (if_id_flush),
      .id_ex_flush      (id_ex_flush),
      .ex_mem_flush     (ex_mem_flush),
      .pipe_hold        (pipe_hold),
      .halted           (halted),
      .mem_timeout      (mem_timeout),
      .stall_count      (stall_count),
      .flush_count      (flush_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic idle();
      id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0; ex_mem_read = 1'b0; ex_rt = 5'd0;
      mem_branch_taken = 1'b0; id_jump = 1'b0; id_halt = 1'b0;
      mem_access = 1'b0; dmem_ready = 1'b1;
   endtask

   // advance to just after the next rising edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      idle();
      reset = 1'b1;
      step();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      idle();
      reset = 1'b1;
      #1;
      n_checks++;
      if (ctl !== C_RESET) begin n_fail++; $display("FAIL reset_ctl got %b want %b", ctl, C_RESET); end
      n_checks++;
      if ({mem_timeout, stall_count, flush_count} !== 33'd0) begin
         n_fail++; $display("FAIL reset_regs got %0d/%0d/%0d want 0/0/0", mem_timeout, stall_count, flush_count);
      end
      step();
      reset = 1'b0;
      #1;
      n_checks++;
      if (ctl !== C_RUN) begin n_fail++; $display("FAIL post_reset_ctl got %b want %b", ctl, C_RUN); end
   endtask

   task automatic test_load_use();
      do_reset();
      ex_mem_read = 1'b1; ex_rt = 5'd2; id_rs = 5'd2;
      #1;
      n_checks++;
      if (ctl !== C_LOAD) begin n_fail++; $display("FAIL lu_rs_ctl got %b want %b", ctl, C_LOAD); end
      step();
      idle();
      #1;
      n_checks++;
      if (stall_count !== 16'd1) begin n_fail++; $display("FAIL lu_rs_count got %0d want 1", stall_count); end
      n_checks++;
      if (ctl !== C_RUN) begin n_fail++; $display("FAIL lu_one_bubble got %b want %b", ctl, C_RUN); end
      ex_mem_read = 1'b1; ex_rt = 5'd0; id_rs = 5'd0;
      #1;
      n_checks++;
      if (ctl !== C_RUN) begin n_fail++; $display("FAIL lu_zero_reg got %b want %b", ctl, C_RUN); end
      step();
      ex_mem_read = 1'b1; ex_rt = 5'd7; id_rs = 5'd3; id_rt = 5'd7; id_uses_rt = 1'b0;
      #1;
      n_checks++;
      if (ctl !== C_RUN) begin n_fail++; $display("FAIL lu_rt_unused got %b want %b", ctl, C_RUN); end
      id_uses_rt = 1'b1;
      #1;
      n_checks++;
      if (ctl !== C_LOAD) begin n_fail++; $display("FAIL lu_rt_used got %b want %b", ctl, C_LOAD); end
      step();
      idle();
      #1;
      n_checks++;
      if (stall_count !== 16'd2) begin n_fail++; $display("FAIL lu_total_count got %0d want 2", stall_count); end
   endtask

   task automatic test_branch_priority();
      do_reset();
      mem_branch_taken = 1'b1; id_halt = 1'b1; id_jump = 1'b1;
      ex_mem_read = 1'b1; ex_rt = 5'd4; id_rs = 5'd4;
      #1;
      n_checks++;
      if (ctl !== C_BRANCH) begin n_fail++; $display("FAIL br_ctl got %b want %b", ctl, C_BRANCH); end
      step();
      idle();
      #1;
      n_checks++;
      if (ctl !== C_RUN) begin n_fail++; $display("FAIL br_stays_run got %b want %b", ctl, C_RUN); end
      n_checks++;
      if ({flush_count, stall_count} !== {16'd1, 16'd0}) begin
         n_fail++; $display("FAIL br_counts got flush=%0d stall=%0d want 1/0", flush_count, stall_count);
      end
   endtask

   task automatic test_jump();
      do_reset();
      id_jump = 1'b1;
      #1;
      n_checks++;
      if (ctl !== C_JUMP) begin n_fail++; $display("FAIL jump_ctl got %b want %b", ctl, C_JUMP); end
      step();
      idle();
      #1;
      n_checks++;
      if (ctl !== C_RUN) begin n_fail++; $display("FAIL jump_after got %b want %b", ctl, C_RUN); end
   endtask

   task automatic test_mem_wait();
      int holds;
      do_reset();
      mem_access = 1'b1; dmem_ready = 1'b1;
      #1;
      n_checks++;
      if (ctl !== C_RUN) begin n_fail++; $display("FAIL mw_zero_wait got %b want %b", ctl, C_RUN); end
      step();
      holds = 0;
      dmem_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         if (ctl === C_FREEZE) holds++;
         step();
      end
      n_checks++;
      if (holds !== 3) begin n_fail++; $display("FAIL mw_freeze_cycles got %0d want 3", holds); end
      dmem_ready = 1'b1; mem_branch_taken = 1'b1;
      #1;
      n_checks++;
      if (ctl !== C_BRANCH) begin n_fail++; $display("FAIL mw_resume_ctl got %b want %b", ctl, C_BRANCH); end
      step();
      idle();
      #1;
      n_checks++;
      if ({stall_count, flush_count} !== {16'd3, 16'd1}) begin
         n_fail++; $display("FAIL mw_counts got stall=%0d flush=%0d want 3/1", stall_count, flush_count);
      end
      n_checks++;
      if (ctl !== C_RUN) begin n_fail++; $display("FAIL mw_back_to_run got %b want %b", ctl, C_RUN); end
   endtask

   task automatic test_timeout();
      int early;
      do_reset();
      mem_access = 1'b1; dmem_ready = 1'b0;
      early = 0;
      for (int i = 0; i < 15; i++) begin
         #1;
         if (ctl !== C_FREEZE || mem_timeout !== 1'b0) early++;
         step();
      end
      n_checks++;
      if (early !== 0) begin n_fail++; $display("FAIL to_frozen_window got %0d bad cycles want 0", early); end
      idle();
      #1;
      n_checks++;
      if ({mem_timeout, ctl} !== {1'b1, C_HALTED}) begin
         n_fail++; $display("FAIL to_raised got %b want %b", {mem_timeout, ctl}, {1'b1, C_HALTED});
      end
      n_checks++;
      if (stall_count !== 16'd15) begin n_fail++; $display("FAIL to_stall_count got %0d want 15", stall_count); end
      mem_branch_taken = 1'b1;
      step(); step(); step();
      #1;
      n_checks++;
      if ({mem_timeout, ctl} !== {1'b1, C_HALTED}) begin
         n_fail++; $display("FAIL to_sticky got %b want %b", {mem_timeout, ctl}, {1'b1, C_HALTED});
      end
      do_reset();
      #1;
      n_checks++;
      if ({mem_timeout, ctl} !== {1'b0, C_RUN}) begin
         n_fail++; $display("FAIL to_cleared got %b want %b", {mem_timeout, ctl}, {1'b0, C_RUN});
      end
   endtask

   task automatic test_drain();
      int bad;
      do_reset();
      id_halt = 1'b1;
      #1;
      n_checks++;
      if (ctl !== C_HALT) begin n_fail++; $display("FAIL dr_halt_ctl got %b want %b", ctl, C_HALT); end
      step();
      idle();
      bad = 0;
      for (int i = 0; i < 4; i++) begin
         #1;
         if (ctl !== C_DRAIN) bad++;
         step();
      end
      n_checks++;
      if (bad !== 0) begin n_fail++; $display("FAIL dr_drain_cycles got %0d bad cycles want 0", bad); end
      #1;
      n_checks++;
      if (ctl !== C_HALTED) begin n_fail++; $display("FAIL dr_halted got %b want %b", ctl, C_HALTED); end
   endtask

   task automatic test_drain_branch();
      int seen_halt;
      do_reset();
      id_halt = 1'b1;
      step();
      idle();
      step();
      mem_branch_taken = 1'b1;
      #1;
      n_checks++;
      if (ctl !== C_BRANCH) begin n_fail++; $display("FAIL drb_ctl got %b want %b", ctl, C_BRANCH); end
      step();
      idle();
      seen_halt = 0;
      for (int i = 0; i < 6; i++) begin
         #1;
         if (halted !== 1'b0 || pc_write !== 1'b1) seen_halt++;
         step();
      end
      n_checks++;
      if (seen_halt !== 0) begin n_fail++; $display("FAIL drb_no_halt got %0d bad cycles want 0", seen_halt); end
      n_checks++;
      if (flush_count !== 16'd1) begin n_fail++; $display("FAIL drb_flush_count got %0d want 1", flush_count); end
   endtask

   task automatic test_reset_mid_drain();
      int bad;
      do_reset();
      ex_mem_read = 1'b1; ex_rt = 5'd9; id_rs = 5'd9;
      step();
      idle();
      id_halt = 1'b1;
      step();
      idle();
      step();
      #2;
      reset = 1'b1;
      #1;
      n_checks++;
      if (ctl !== C_RESET) begin n_fail++; $display("FAIL rmd_async_ctl got %b want %b", ctl, C_RESET); end
      n_checks++;
      if (stall_count !== 16'd0) begin n_fail++; $display("FAIL rmd_async_count got %0d want 0", stall_count); end
      step();
      reset = 1'b0;
      bad = 0;
      for (int i = 0; i < 6; i++) begin
         #1;
         if (ctl !== C_RUN) bad++;
         step();
      end
      n_checks++;
      if (bad !== 0) begin n_fail++; $display("FAIL rmd_run_after got %0d bad cycles want 0", bad); end
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_branch_priority();
      test_jump();
      test_mem_wait();
      test_timeout();
      test_drain();
      test_drain_branch();
      test_reset_mid_drain();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pipeline_hazard_controller.md
# pipeline_hazard_controller

Central sequencing controller for the 5-stage pipelined MIPS core. It produces the PC and pipeline-register write/flush controls and resolves the following hazards:
- load-use stalls
- taken-branch flushes (branch resolved in MEM)
- jump squashes
- multi-cycle data-memory wait states
- a halt/drain sequence

It sits beside the Forwarding Unit and drives the enables of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.

## Interface
Parameters:
- MEM_TIMEOUT, 15, max consecutive wait cycles before `mem_timeout` is raised
- DRAIN_CYCLES, 4, cycles the pipeline runs in DRAIN before HALTED
- CNT_W, 16, width of the performance counters

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- id_rs, id_rt  in  5 each  source registers of the instruction in ID
- id_uses_rt  in  1  ID instruction reads rt as a source (R-type, beq, sw)
- ex_mem_read  in  1  instruction in EX is a load (memToReg)
- ex_rt  in  5  destination register of that load
- mem_branch_taken  in  1  beq in MEM with zero flag set
- id_jump  in  1  jump decoded in ID
- id_halt  in  1  halt decoded in ID
- mem_access  in  1  load/store present in MEM
- dmem_ready  in  1  data memory completes this cycle
- pc_write  out  1  PC load enable
- if_id_write  out  1  IF/ID load enable
- if_id_flush, id_ex_flush, ex_mem_flush  out  1 each  load a bubble (all controls 0)
- pipe_hold  out  1  freeze ID/EX, EX/MEM, MEM/WB
- halted  out  1  core stopped
- mem_timeout  out  1  sticky error flag
- stall_count, flush_count  out  CNT_W each  saturating performance counters

## Operation
- FSM states: RUN, MEM_WAIT, DRAIN, HALTED. The state register is the only storage besides `wait_cnt`, `drain_cnt`, the two perf counters and `mem_timeout`.
- Default outputs: `pc_write` = `if_id_write` = 1; every other output 0.
- RUN evaluates the following each cycle; the first match wins:
  1. **Memory wait.** `mem_access` & !`dmem_ready` → FREEZE. FREEZE means `pc_write` = `if_id_write` = 0, `pipe_hold` = 1, no flushes. Next state MEM_WAIT, `wait_cnt` = 1. When `dmem_ready` is high in the same cycle, the access is zero-wait and costs no stall.
  2. **Taken branch.** `mem_branch_taken` → assert all three flushes; `pc_write` = 1 (branch target). `flush_count` +1. A halt or jump in ID is squashed.
  3. **Halt.** `id_halt` → `pc_write` = 0, `if_id_flush` = 1, `id_ex_flush` = 1; go to DRAIN with `drain_cnt` = 0.
  4. **Load-use.** `ex_mem_read` & `ex_rt` != 0 & (`ex_rt` == `id_rs` | (`id_uses_rt` & `ex_rt` == `id_rt`)) → `pc_write` = `if_id_write` = 0, `id_ex_flush` = 1. `stall_count` +1.
  5. **Jump.** `id_jump` → `if_id_flush` = 1. `pc_write` stays 1 (jump target).
- MEM_WAIT:
  - FREEZE each cycle, `stall_count` +1, `wait_cnt` +1.
  - On `dmem_ready`: no freeze. RUN rules 2–5 apply this cycle; next state RUN.
  - When `wait_cnt` == MEM_TIMEOUT without ready: set `mem_timeout`, go to HALTED.
- DRAIN:
  - `pc_write` = 0 and `if_id_flush` = 1 every cycle; the older instructions advance.
  - A memory wait uses FREEZE, pauses `drain_cnt`, and is tracked by `wait_cnt` exactly as in MEM_WAIT (timeout → HALTED).
  - `mem_branch_taken` means the halt was on the wrong path: apply the rule-2 outputs, return to RUN.
  - When `drain_cnt` == DRAIN_CYCLES-1 → HALTED.
- HALTED: `pc_write` = `if_id_write` = 0, `pipe_hold` = 1, `halted` = 1. The state is left only by reset.
- Counters saturate at 2^CNT_W-1 and never wrap.

## Timing
- Control outputs are combinational from the current state and inputs, so a stall or flush takes effect at the clock edge ending the cycle in which it is detected. State and counters update on the rising edge of `clk`.
- Latencies:
  - load-use: 1 bubble
  - taken branch: 3 squashed instructions
  - jump: 1 squashed instruction
  - memory wait: N frozen cycles for N cycles of !`dmem_ready`
- While `reset` = 1, and immediately on its assertion (asynchronous):
  - state RUN, all counters 0, `mem_timeout` = 0
  - `pc_write` = `if_id_write` = 0, all three flushes = 1, `pipe_hold` = 0, `halted` = 0
- Reset asserted mid-MEM_WAIT or mid-DRAIN aborts the sequence immediately.
- On the first edge after release, normal RUN behaviour applies.

## Structure
- Package `mips_ctrl_pkg` holds:
  - the FSM state enum (RUN, MEM_WAIT, DRAIN, HALTED)
  - `REG_ZERO` = 5'd0
  - the default MEM_TIMEOUT and DRAIN_CYCLES constants
- Sub-module `load_use_detect` contains the purely combinational rs/rt comparator (rule 4) so it can be unit-tested.

## Test plan
- lw $2 in EX (`ex_rt` = 2), `id_rs` = 2 → one cycle with `pc_write` = 0, `id_ex_flush` = 1, `stall_count` = 1. Repeat with `ex_rt` = 0 → no stall.
- `mem_branch_taken` = 1 in the same cycle as `id_halt` and a load-use hazard → three flushes, `pc_write` = 1, state stays RUN, `flush_count` = 1.
- `mem_access` = 1 with `dmem_ready` low for 3 cycles → `pipe_hold` = 1 for exactly 3 cycles, `stall_count` = 3, resume on the 4th cycle.
- `dmem_ready` held low with MEM_TIMEOUT = 15 → `mem_timeout` and `halted` rise after 15 frozen cycles and stay high until reset.
- `id_halt` → DRAIN; `halted` = 1 after 4 cycles. Variant: `mem_branch_taken` on DRAIN cycle 2 → return to RUN, `halted` never asserts.
- Assert `reset` mid-DRAIN → outputs take their reset values with no clock edge; after release, state RUN and counters 0.
